// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-side handshake and ID/EX control bundle of the MINI-RISC control stage
interface pipe_ctrl_if #(parameter int OPCODE_W = 5);
  logic                id_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                stall_in;
  logic                flush_in;
  logic                id_ready;
  logic                ex_valid;
  logic                ex_alu_src;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                ex_mem_to_reg;
  logic                ex_branch;
  logic                ex_jump;
  logic                ex_alu_op;
  logic [1:0]          ex_write_mode;
  logic                busy;
  logic                halted;
  logic                illegal_err;
  modport master (
    output id_valid, opcode, stall_in, flush_in,
    input  id_ready, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_branch, ex_jump, ex_alu_op, ex_write_mode, busy, halted, illegal_err
  );
  modport slave (
    input  id_valid, opcode, stall_in, flush_in,
    output id_ready, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_branch, ex_jump, ex_alu_op, ex_write_mode, busy, halted, illegal_err
  );
endinterface

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: registered ID/EX control stage with stall/flush/bubble, multi-cycle MUL/DIV and HALT (option: ILLEGAL_TRAP_EN traps undefined opcodes)
module pipe_control_unit #(
  parameter int OPCODE_W = 5,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 8,
  parameter int CNT_W    = 4
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);
  localparam logic [OPCODE_W-1:0]
    OP_ADD  = OPCODE_W'(0),  OP_SUB    = OPCODE_W'(1),  OP_NOT    = OPCODE_W'(2),
    OP_AND  = OPCODE_W'(3),  OP_OR     = OPCODE_W'(4),  OP_XOR    = OPCODE_W'(5),
    OP_INC  = OPCODE_W'(6),  OP_CMP    = OPCODE_W'(7),  OP_RR     = OPCODE_W'(8),
    OP_RL   = OPCODE_W'(9),  OP_SETB   = OPCODE_W'(10), OP_CLRB   = OPCODE_W'(11),
    OP_CPLB = OPCODE_W'(12), OP_MUL    = OPCODE_W'(13), OP_DIV    = OPCODE_W'(14),
    OP_SETF = OPCODE_W'(15), OP_CLRF   = OPCODE_W'(16), OP_CPLF   = OPCODE_W'(17),
    OP_LOAD = OPCODE_W'(18), OP_STORE  = OPCODE_W'(19), OP_LBL    = OPCODE_W'(20),
    OP_LBH  = OPCODE_W'(21), OP_MOV    = OPCODE_W'(22), OP_MOVOUT = OPCODE_W'(23),
    OP_MOVIN = OPCODE_W'(24), OP_MOVB  = OPCODE_W'(25), OP_JF     = OPCODE_W'(26),
    OP_LOADBR = OPCODE_W'(27), OP_HALT = OPCODE_W'(28);
  // Counter entry values; a latency of 1 never enters MULTI so its entry is unused.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
  typedef enum logic [1:0] {RUN, MULTI, HALTED} state_t;
  typedef struct packed {
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_op;
    logic [1:0] wm;
  } ctrl_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            bun_q, bun_d, dec;
  logic             ex_valid_q, ex_valid_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             accept, is_halt, is_mul, is_div, multi;
  assign bus.id_ready = rst_n && state_q == RUN && !bus.stall_in && !bus.flush_in;
  assign accept       = bus.id_valid && bus.id_ready;
  assign is_halt      = bus.opcode == OP_HALT;
  assign is_mul       = bus.opcode == OP_MUL;
  assign is_div       = bus.opcode == OP_DIV;
  assign multi        = (is_mul && MUL_LAT > 1) || (is_div && DIV_LAT > 1);
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d, is_ill;
  // Encodings are contiguous, so anything above HALT is undefined.
  assign is_ill          = bus.opcode > OP_HALT;
  assign bus.illegal_err = illegal_q;
`else
  assign bus.illegal_err = 1'b0;
`endif
  // Opcode decode into the control bundle; HALT and undefined opcodes decode to all zero.
  always_comb begin
    dec = '0;
    case (bus.opcode)
      OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_INC, OP_CMP, OP_RR, OP_RL,
      OP_SETB, OP_CLRB, OP_CPLB, OP_MUL, OP_DIV: begin
        dec.reg_write = 1'b1;
        dec.wm        = 2'b11;
        dec.alu_op    = 1'b1;
      end
      OP_SETF, OP_CLRF, OP_CPLF: dec.alu_op = 1'b1;
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.wm         = 2'b11;
      end
      OP_STORE: dec.mem_write = 1'b1;
      OP_LBL: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.wm        = 2'b01;
      end
      OP_LBH: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.wm        = 2'b10;
      end
      OP_MOV, OP_MOVOUT, OP_MOVIN, OP_MOVB: begin
        dec.reg_write = 1'b1;
        dec.wm        = 2'b11;
      end
      OP_JF:     dec.branch = 1'b1;
      OP_LOADBR: dec.jump   = 1'b1;
      default:   dec = '0;
    endcase
  end
  // Next-state: bubble by default; flush wins in RUN/MULTI; HALTED only leaves through reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bun_d      = '0;
    ex_valid_d = 1'b0;
    busy_d     = 1'b0;
    halted_d   = halted_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    case (state_q)
      RUN: begin
        if (bus.flush_in) begin
          cnt_d = '0;
        end else if (accept) begin
          bun_d = dec;
          if (is_halt) begin
            ex_valid_d = 1'b1;
            halted_d   = 1'b1;
            state_d    = HALTED;
`ifdef ILLEGAL_TRAP_EN
          end else if (is_ill) begin
            ex_valid_d = 1'b1;
            halted_d   = 1'b1;
            illegal_d  = 1'b1;
            state_d    = HALTED;
`endif
          end else if (multi) begin
            busy_d  = 1'b1;
            cnt_d   = is_mul ? MUL_CNT : DIV_CNT;
            state_d = MULTI;
          end else begin
            ex_valid_d = 1'b1;
          end
        end
      end
      MULTI: begin
        if (bus.flush_in) begin
          cnt_d   = '0;
          state_d = RUN;
        end else if (cnt_q == '0) begin
          bun_d      = bun_q;
          ex_valid_d = 1'b1;
          state_d    = RUN;
        end else begin
          bun_d  = bun_q;
          busy_d = 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      default: state_d = HALTED;
    endcase
  end
  // ID/EX register and FSM state; reset discards any in-flight multi-cycle op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      bun_q      <= '0;
      ex_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bun_q      <= bun_d;
      ex_valid_q <= ex_valid_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end
`ifdef ILLEGAL_TRAP_EN
  // Sticky undefined-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
`endif
  assign bus.ex_valid      = ex_valid_q;
  assign bus.busy          = busy_q;
  assign bus.halted        = halted_q;
  assign bus.ex_alu_src    = bun_q.alu_src;
  assign bus.ex_reg_write  = bun_q.reg_write;
  assign bus.ex_mem_read   = bun_q.mem_read;
  assign bus.ex_mem_write  = bun_q.mem_write;
  assign bus.ex_mem_to_reg = bun_q.mem_to_reg;
  assign bus.ex_branch     = bun_q.branch;
  assign bus.ex_jump       = bun_q.jump;
  assign bus.ex_alu_op     = bun_q.alu_op;
  assign bus.ex_write_mode = bun_q.wm;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed checks of pipe_control_unit (default MUL_LAT=3, DIV_LAT=8)
module tb_pipe_control_unit;
  localparam logic [4:0] ADD = 5'd0, MUL = 5'd13, DIV = 5'd14, LOAD = 5'd18, STORE = 5'd19;
  localparam logic [4:0] LBH = 5'd21, HALT = 5'd28, UNDEF = 5'd31;
  // {alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_op, wm[1:0]}
  localparam logic [9:0] B_ADD   = 10'b0100000111;
  localparam logic [9:0] B_LOAD  = 10'b0110100011;
  localparam logic [9:0] B_LBH   = 10'b1100000010;
  localparam logic [9:0] B_STORE = 10'b0001000000;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic [9:0] ex_bun;
  always #5 clk = ~clk;
  pipe_ctrl_if #(.OPCODE_W(5)) bus ();
  pipe_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign ex_bun = {bus.ex_alu_src, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                   bus.ex_mem_to_reg, bus.ex_branch, bus.ex_jump, bus.ex_alu_op, bus.ex_write_mode};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.id_valid = 1'b1;
    bus.opcode   = ADD;
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;
    repeat (2) tick;
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_bundle", ex_bun, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_illegal", bus.illegal_err, 0);
    check("rst_id_ready", bus.id_ready, 0);
    rst_n = 1'b1;
    #1;
    check("rel_id_ready", bus.id_ready, 1);
    tick;
    check("add_valid", bus.ex_valid, 1);
    check("add_bundle", ex_bun, B_ADD);
    bus.opcode = LOAD;
    tick;
    check("load_valid", bus.ex_valid, 1);
    check("load_bundle", ex_bun, B_LOAD);
    bus.opcode = LBH;
    tick;
    check("lbh_valid", bus.ex_valid, 1);
    check("lbh_bundle", ex_bun, B_LBH);
    bus.opcode = MUL;
    tick;
    check("mul_c1_busy", bus.busy, 1);
    check("mul_c1_valid", bus.ex_valid, 0);
    check("mul_c1_ready", bus.id_ready, 0);
    bus.opcode = ADD;
    tick;
    check("mul_c2_busy", bus.busy, 1);
    check("mul_c2_valid", bus.ex_valid, 0);
    check("mul_c2_ready", bus.id_ready, 0);
    tick;
    check("mul_c3_valid", bus.ex_valid, 1);
    check("mul_c3_busy", bus.busy, 0);
    check("mul_c3_bundle", ex_bun, B_ADD);
    check("mul_c3_ready", bus.id_ready, 1);
    tick;
    check("add_after_mul_valid", bus.ex_valid, 1);
    check("add_after_mul_busy", bus.busy, 0);
    bus.opcode = DIV;
    tick;
    check("div_busy", bus.busy, 1);
    bus.id_valid = 1'b0;
    repeat (3) tick;
    check("div_c4_busy", bus.busy, 1);
    bus.flush_in = 1'b1;
    #1;
    check("flush_ready", bus.id_ready, 0);
    tick;
    bus.flush_in = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_valid", bus.ex_valid, 0);
    check("flush_bundle", ex_bun, 0);
    bus.id_valid = 1'b1;
    bus.opcode   = ADD;
    #1;
    check("post_flush_ready", bus.id_ready, 1);
    tick;
    check("post_flush_add_valid", bus.ex_valid, 1);
    check("post_flush_add_bundle", ex_bun, B_ADD);
    bus.id_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("div_never_valid", bus.ex_valid, 0);
    end
    bus.id_valid = 1'b1;
    bus.opcode   = STORE;
    bus.stall_in = 1'b1;
    #1;
    check("stall_ready", bus.id_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick;
      check("stall_bubble_valid", bus.ex_valid, 0);
      check("stall_bubble_bundle", ex_bun, 0);
    end
    bus.stall_in = 1'b0;
    tick;
    check("store_valid", bus.ex_valid, 1);
    check("store_bundle", ex_bun, B_STORE);
    bus.opcode = MUL;
    tick;
    check("mid_mul_busy", bus.busy, 1);
    bus.id_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_bundle", ex_bun, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("discarded_mul_valid", bus.ex_valid, 0);
    end
    bus.id_valid = 1'b1;
    bus.opcode   = UNDEF;
    tick;
    bus.id_valid = 1'b0;
    check("undef_valid", bus.ex_valid, 1);
    check("undef_bundle", ex_bun, 0);
`ifdef ILLEGAL_TRAP_EN
    check("undef_illegal", bus.illegal_err, 1);
    check("undef_halted", bus.halted, 1);
    check("undef_ready", bus.id_ready, 0);
    tick;
    check("illegal_sticky", bus.illegal_err, 1);
`else
    check("undef_illegal", bus.illegal_err, 0);
    check("undef_halted", bus.halted, 0);
    check("undef_ready", bus.id_ready, 1);
`endif
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    bus.id_valid = 1'b1;
    bus.opcode   = HALT;
    tick;
    check("halt_valid", bus.ex_valid, 1);
    check("halt_bundle", ex_bun, 0);
    check("halt_halted", bus.halted, 1);
    bus.opcode = ADD;
    #1;
    check("halted_ready", bus.id_ready, 0);
    tick;
    check("halted_bubble", bus.ex_valid, 0);
    bus.flush_in = 1'b1;
    tick;
    bus.flush_in = 1'b0;
    check("halted_flush_halted", bus.halted, 1);
    check("halted_flush_valid", bus.ex_valid, 0);
    check("halted_flush_ready", bus.id_ready, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
